// File: rtl/sti_dac_pkg.sv
// Shared types and frame-building helper for the STI/DAC serial transmitter.
package sti_dac_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;

  localparam int DEF_MAX_BYTES = 4;
  localparam int LEN_W         = $clog2(DEF_MAX_BYTES);
  localparam int FRAME_MAX     = 256;

  // Places data_w bits of data into an F-bit frame, F = (len+1)*8; bits above F are zero.
  function automatic logic [FRAME_MAX-1:0] build_frame(
    input logic [FRAME_MAX-1:0] data,
    input int unsigned          data_w,
    input int unsigned          len,
    input logic                 fill,
    input logic                 low
  );
    int unsigned          f;
    logic [FRAME_MAX-1:0] mask;
    logic [FRAME_MAX-1:0] d;
    logic [FRAME_MAX-1:0] r;
    f    = (len + 1) * 8;
    mask = {FRAME_MAX{1'b1}} >> (FRAME_MAX - f);
    d    = data & ({FRAME_MAX{1'b1}} >> (FRAME_MAX - data_w));
    if (f == data_w)
      r = d;
    else if (f < data_w)
      r = low ? (d >> (data_w - f)) : (d & mask);
    else
      r = fill ? (d << (f - data_w)) : d;
    return r & mask;
  endfunction

endpackage

// File: rtl/sti_byte_packer.sv
// Collects the serial stream into bytes and writes them round-robin across the banks.
module sti_byte_packer
  import sti_dac_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_vld,
  output logic [7:0]           byte_out,
  output logic [ADDR_W-1:0]    addr,
  output logic [NUM_BANKS-1:0] wr
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int NW = BW + ADDR_W;

  logic [6:0]    sh;
  logic [2:0]    bcnt;
  logic [NW-1:0] n;

  // Byte counter n wraps naturally: low bits pick the bank, high bits the address.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt     <= '0;
      n        <= '0;
      wr       <= '0;
      addr     <= '0;
      byte_out <= '0;
    end else begin
      wr <= '0;
      if (bit_vld) begin
        bcnt <= bcnt + 3'd1;
        if (bcnt == 3'd7) begin
          byte_out <= {sh, bit_in};
          addr     <= n[BW +: ADDR_W];
          wr       <= NUM_BANKS'(1) << n[BW-1:0];
          n        <= n + NW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bit_vld) sh <= {sh[5:0], bit_in};
  end

endmodule

// File: rtl/sti_dac_p.sv
// Parametrised serial transmitter feeding a banked byte writer.
// Optional STI_DAC_PARITY_EN appends an even-parity bit after each frame.
module sti_dac_p
  import sti_dac_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MAX_BYTES = 4,
  parameter int NUM_BANKS = 8,
  parameter int ADDR_W    = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [DATA_W-1:0]            pi_data,
  input  logic [$clog2(MAX_BYTES)-1:0] pi_length,
  input  logic                         pi_fill,
  input  logic                         pi_msb,
  input  logic                         pi_low,
  input  logic                         pi_end,
  output logic                         busy,
  output logic                         so_data,
  output logic                         so_valid,
  output logic [7:0]                   oem_dataout,
  output logic [ADDR_W-1:0]            oem_addr,
  output logic [NUM_BANKS-1:0]         oem_wr,
  output logic                         oem_finish
);

  localparam int FW = MAX_BYTES * 8;
  localparam int IW = $clog2(FW);

  state_t        state;
  logic [FW-1:0] frame;
  logic [FW-1:0] frame_new;
  logic [IW-1:0] cnt;
  logic [IW-1:0] lst;
  logic [IW-1:0] idx;
  logic          last_q;
  logic          msb_q;
  logic          end_q;
  logic          pack_vld;

  assign frame_new = FW'(build_frame(FRAME_MAX'(pi_data), DATA_W, 32'(pi_length), pi_fill, pi_low));
  assign idx       = msb_q ? (lst - cnt) : cnt;
  assign pack_vld  = so_valid && (state != PAR);

  // Bit 0 of the transmit order leaves on the load edge; cnt walks the remaining F-1 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      so_valid   <= 1'b0;
      so_data    <= 1'b0;
      oem_finish <= 1'b0;
      cnt        <= '0;
      lst        <= '0;
      last_q     <= 1'b0;
      msb_q      <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state    <= SHIFT;
            busy     <= 1'b1;
            lst      <= {pi_length, 3'b111};
            msb_q    <= pi_msb;
            end_q    <= pi_end;
            cnt      <= IW'(1);
            last_q   <= 1'b0;
            so_valid <= 1'b1;
            so_data  <= pi_msb ? frame_new[{pi_length, 3'b111}] : frame_new[0];
          end else begin
            so_valid <= 1'b0;
            so_data  <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_q) begin
`ifdef STI_DAC_PARITY_EN
            so_valid <= 1'b1;
            so_data  <= ^frame;
            state    <= PAR;
`else
            so_valid <= 1'b0;
            so_data  <= 1'b0;
            state    <= end_q ? DONE : IDLE;
            busy     <= end_q;
`endif
          end else begin
            so_valid <= 1'b1;
            so_data  <= frame[idx];
            cnt      <= cnt + IW'(1);
            last_q   <= (cnt == lst);
          end
        end
        PAR: begin
          so_valid   <= 1'b0;
          so_data    <= 1'b0;
          state      <= end_q ? DONE : IDLE;
          busy       <= end_q;
          oem_finish <= end_q;
        end
        DONE: begin
          so_valid   <= 1'b0;
          so_data    <= 1'b0;
          oem_finish <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && load) frame <= frame_new;
  end

  sti_byte_packer #(
    .NUM_BANKS(NUM_BANKS),
    .ADDR_W   (ADDR_W)
  ) u_packer (
    .clk     (clk),
    .reset   (reset),
    .bit_in  (so_data),
    .bit_vld (pack_vld),
    .byte_out(oem_dataout),
    .addr    (oem_addr),
    .wr      (oem_wr)
  );

endmodule

// File: tb/tb_sti_dac_p.sv
// Self-checking bench for sti_dac_p: directed vector table, reset/ignore/finish sequences, random stream.
module tb_sti_dac_p;

  logic        clk = 1'b0;
  logic        reset, load, pi_fill, pi_msb, pi_low, pi_end;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        busy, so_data, so_valid, oem_finish;
  logic [7:0]  oem_dataout;
  logic [4:0]  oem_addr;
  logic [7:0]  oem_wr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [4:0] a;
    logic [7:0] w;
  } wr_t;

  typedef struct {
    logic [15:0] d;
    int          len;
    logic        fill, msb, low;
    int          nb;
    logic [7:0]  b[4];
    logic [7:0]  w0;
  } vec_t;

  wr_t  wq[$];
  wr_t  last_w[$];
  logic sq[$];
  int   cyc = 0;
  int   last_wr_cyc = 0;
  int   fin_cyc = -1;
  int   mdl_n = 0;

  sti_dac_p dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .pi_data    (pi_data),
    .pi_length  (pi_length),
    .pi_fill    (pi_fill),
    .pi_msb     (pi_msb),
    .pi_low     (pi_low),
    .pi_end     (pi_end),
    .busy       (busy),
    .so_data    (so_data),
    .so_valid   (so_valid),
    .oem_dataout(oem_dataout),
    .oem_addr   (oem_addr),
    .oem_wr     (oem_wr),
    .oem_finish (oem_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (oem_wr != 8'h00) begin
      e.d = oem_dataout;
      e.a = oem_addr;
      e.w = oem_wr;
      wq.push_back(e);
      last_wr_cyc = cyc;
    end
    if (so_valid) sq.push_back(so_data);
    else chk("so_data_idle", 32'(so_data), 0);
    if (oem_finish && fin_cyc < 0) fin_cyc = cyc;
  end

  function automatic logic [31:0] mdl_frame(input logic [15:0] d, input int len,
                                            input logic fill, input logic low);
    int          f;
    logic [31:0] v;
    f = (len + 1) * 8;
    v = {16'h0, d};
    if (f < 16) v = low ? (v >> (16 - f)) : (v % (32'd1 << f));
    else if (f > 16 && fill) v = v << (f - 16);
    return v;
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_so_valid"}, 32'(so_valid), 0);
    chk({nm, "_so_data"}, 32'(so_data), 0);
    chk({nm, "_wr"}, 32'(oem_wr), 0);
    chk({nm, "_dataout"}, 32'(oem_dataout), 0);
    chk({nm, "_addr"}, 32'(oem_addr), 0);
    chk({nm, "_finish"}, 32'(oem_finish), 0);
  endtask

  task automatic run_frame(input logic [15:0] d, input int len, input logic fill, input logic msb,
                           input logic low, input logic endf, input int mid_load);
    logic [31:0] fr;
    int          f, g, base;
    logic        eb[$];
    wr_t         ew[$];
    wr_t         e;
    logic [7:0]  by;
    fr = mdl_frame(d, len, fill, low);
    f  = (len + 1) * 8;
    for (int i = 0; i < f; i++) eb.push_back(msb ? fr[f-1-i] : fr[i]);
    base = mdl_n;
    for (int b = 0; b < f / 8; b++) begin
      by = 8'h00;
      for (int k = 0; k < 8; k++) by = {by[6:0], eb[b*8+k]};
      e.d = by;
      e.a = 5'((mdl_n / 8) % 32);
      e.w = 8'(1) << (mdl_n % 8);
      ew.push_back(e);
      mdl_n++;
    end
`ifdef STI_DAC_PARITY_EN
    eb.push_back(^fr);
`endif
    g = 0;
    while (busy && g < 100) begin @(posedge clk); #1; g++; end
    chk("idle_before_load", 32'(busy), 0);
    pi_data = d; pi_length = 2'(len); pi_fill = fill; pi_msb = msb; pi_low = low; pi_end = endf;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("first_valid", 32'(so_valid), 1);
    chk("busy_after_load", 32'(busy), 1);
    if (mid_load != 0) begin
      repeat (mid_load) begin @(posedge clk); #1; end
      pi_data = ~d; pi_length = 2'd0; pi_msb = ~msb; pi_end = 1'b1;
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      chk("busy_mid_load", 32'(busy), 1);
    end
    g = 0;
    while ((wq.size() < ew.size() || sq.size() < eb.size() || so_valid) && g < 150) begin
      @(posedge clk); #1; g++;
    end
    @(posedge clk); #1;
    chk("n_bits", sq.size(), eb.size());
    for (int i = 0; i < eb.size() && i < sq.size(); i++)
      chk($sformatf("bit%0d", i), 32'(sq[i]), 32'(eb[i]));
    chk("n_bytes", wq.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
      chk($sformatf("byte%0d_data", base + i), 32'(wq[i].d), 32'(ew[i].d));
      chk($sformatf("byte%0d_addr", base + i), 32'(wq[i].a), 32'(ew[i].a));
      chk($sformatf("byte%0d_wr", base + i), 32'(wq[i].w), 32'(ew[i].w));
      if (base + i == 256) begin
        chk("wrap_addr", 32'(wq[i].a), 0);
        chk("wrap_wr", 32'(wq[i].w), 32'h01);
      end
    end
    last_w = wq;
    wq.delete();
    sq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    vec_t vt[3];
    int   g;
    vt[0] = '{d:16'hA55A, len:0, fill:1'b0, msb:1'b1, low:1'b1, nb:1,
              b:'{8'hA5, 8'h00, 8'h00, 8'h00}, w0:8'h01};
    vt[1] = '{d:16'h1234, len:1, fill:1'b0, msb:1'b0, low:1'b0, nb:2,
              b:'{8'h2C, 8'h48, 8'h00, 8'h00}, w0:8'h02};
    vt[2] = '{d:16'hBEEF, len:3, fill:1'b0, msb:1'b1, low:1'b0, nb:4,
              b:'{8'h00, 8'h00, 8'hBE, 8'hEF}, w0:8'h08};

    reset = 1'b1; load = 1'b0; pi_data = '0; pi_length = '0;
    pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    for (int t = 0; t < 3; t++) begin
      run_frame(vt[t].d, vt[t].len, vt[t].fill, vt[t].msb, vt[t].low, 1'b0, 0);
      chk($sformatf("vec%0d_count", t), last_w.size(), vt[t].nb);
      for (int i = 0; i < vt[t].nb && i < last_w.size(); i++)
        chk($sformatf("vec%0d_byte%0d", t, i), 32'(last_w[i].d), 32'(vt[t].b[i]));
      if (last_w.size() > 0) begin
        chk($sformatf("vec%0d_wr0", t), 32'(last_w[0].w), 32'(vt[t].w0));
        chk($sformatf("vec%0d_addr0", t), 32'(last_w[0].a), 0);
      end
    end

    // load while shifting must not disturb the running frame
    run_frame(16'h5AC3, 3, 1'b1, 1'b0, 1'b0, 1'b0, 3);

    // reset after a few bits: everything clears and the byte counter restarts
    pi_data = 16'hC3A5; pi_length = 2'd3; pi_msb = 1'b1; pi_fill = 1'b1; pi_end = 1'b0;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    g = 0;
    while (sq.size() < 5 && g < 50) begin @(posedge clk); #1; g++; end
    chk("bits_before_reset", sq.size(), 5);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_zero("mid_reset");
    reset = 1'b0;
    sq.delete(); wq.delete(); mdl_n = 0; fin_cyc = -1;
    run_frame(16'h0F0F, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    if (last_w.size() > 0) begin
      chk("post_reset_wr", 32'(last_w[0].w), 32'h01);
      chk("post_reset_addr", 32'(last_w[0].a), 0);
    end else chk("post_reset_count", 0, 1);

    // random stream long enough to wrap the byte counter
    while (mdl_n < 262)
      run_frame(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                1'($urandom), 1'b0, 0);

    // last frame: sticky finish, later loads ignored
    run_frame(16'hBEEF, 2, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    chk("end_count", last_w.size(), 3);
    if (last_w.size() == 3) begin
      chk("end_b0", 32'(last_w[0].d), 32'hBE);
      chk("end_b1", 32'(last_w[1].d), 32'hEF);
      chk("end_b2", 32'(last_w[2].d), 32'h00);
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("finish_high", 32'(oem_finish), 1);
    chk("finish_timing", 32'(fin_cyc), 32'(last_wr_cyc + 1));
    pi_data = 16'hFFFF; pi_length = 2'd1; pi_end = 1'b0;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    chk("done_no_bits", sq.size(), 0);
    chk("done_no_writes", wq.size(), 0);
    chk("done_busy", 32'(busy), 1);
    chk("done_finish_sticky", 32'(oem_finish), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
